// File: rtl/cache_fill_arbiter.sv
// ---------------------------------------------------------------------------
// cache_fill_arbiter
//
// Shares one memory port between an I-cache block fill, a D-cache block fill
// and D-side write-through stores. Only one transaction owns the port at a
// time. A fill issues BLOCK_WORDS back-to-back reads and forwards every
// returned word to the owning cache. The last return pulses the owner's done.
//
// Optional build macro:
//   ARB_RR_EN - round-robin between d_miss and i_miss on a tie. A 1-bit
//               "last granted" pointer picks the other side, and it resets to
//               "I last". When undefined, d_miss always beats i_miss.
//               d_wr always wins in both builds.
//
// Parameters:
//   MEM_LATENCY  - cycles from a read issue to its mem_data_valid (>= 1)
//   BLOCK_WORDS  - 16-bit words per block (8 -> 16-byte block)
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   i_miss, i_addr                  I-side fill request / miss byte address
//   d_miss, d_addr                  D-side fill request / miss byte address
//   d_wr, d_wr_addr, d_wr_data      D-side write-through request
//   mem_en, mem_wr, mem_addr,
//   mem_data_in                     shared memory port (request side)
//   mem_data_out, mem_data_valid    shared memory port (read return)
//   fill_data, fill_word            returned word and its offset in the block
//   i_fill_we, d_fill_we            per-cache fill write enables
//   i_done, d_done, d_wr_ack        one-cycle completion pulses
//   busy                            high whenever not IDLE
// ---------------------------------------------------------------------------
module cache_fill_arbiter #(
    parameter int MEM_LATENCY = 4,
    parameter int BLOCK_WORDS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_miss,
    input  logic [15:0] i_addr,
    input  logic        d_miss,
    input  logic [15:0] d_addr,
    input  logic        d_wr,
    input  logic [15:0] d_wr_addr,
    input  logic [15:0] d_wr_data,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic [15:0] mem_data_out,
    input  logic        mem_data_valid,
    output logic [15:0] fill_data,
    output logic [2:0]  fill_word,
    output logic        i_fill_we,
    output logic        d_fill_we,
    output logic        i_done,
    output logic        d_done,
    output logic        d_wr_ack,
    output logic        busy
);

    localparam int CW = $clog2(BLOCK_WORDS);

    // The block/offset arithmetic assumes 16-byte blocks of 16-bit words.
    // A return must also land at least one cycle after its issue.
    generate
        if (MEM_LATENCY < 1 || BLOCK_WORDS != 8) begin : g_cfg_check
            $error("cache_fill_arbiter: unsupported MEM_LATENCY/BLOCK_WORDS");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DRAIN} state_t;

    state_t          state_reg, state_next;
    logic            owner_reg, owner_next;          // 1 = D-cache, 0 = I-cache
    logic [15:0]     base_reg, base_next;
    logic [CW-1:0]   issue_cnt_reg, issue_cnt_next;
    logic [CW-1:0]   ret_cnt_reg, ret_cnt_next;

    logic            grant_d;
    logic            ret_fire;
    logic            last_ret;
    logic [1:0]      fill_we_vec;
    logic [1:0]      done_vec;

    // Miss arbitration between the two caches (d_wr is handled ahead of this)
`ifdef ARB_RR_EN
    logic last_d_reg;                                // 1 = D granted last

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_d_reg <= 1'b0;
        end else if (state_reg == IDLE && !d_wr && (d_miss || i_miss)) begin
            last_d_reg <= grant_d;
        end
    end

    assign grant_d = d_miss && (!i_miss || !last_d_reg);
`else
    assign grant_d = d_miss;
`endif

    // Returns are only meaningful while a fill owns the port; a stray valid
    // in IDLE or WRITE is dropped without touching the return counter.
    assign ret_fire = mem_data_valid && (state_reg == FILL || state_reg == DRAIN);
    assign last_ret = ret_fire && (ret_cnt_reg == CW'(BLOCK_WORDS - 1));

    // Steer the write enable and done pulse to the cache that owns the fill
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            localparam logic SIDE = (gi == 1);
            assign fill_we_vec[gi] = ret_fire && (owner_reg == SIDE);
            assign done_vec[gi]    = last_ret && (owner_reg == SIDE);
        end
    endgenerate

    assign i_fill_we = fill_we_vec[0];
    assign d_fill_we = fill_we_vec[1];
    assign i_done    = done_vec[0];
    assign d_done    = done_vec[1];
    assign busy      = (state_reg != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            owner_reg     <= 1'b0;
            base_reg      <= 16'h0000;
            issue_cnt_reg <= '0;
            ret_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            base_reg      <= base_next;
            issue_cnt_reg <= issue_cnt_next;
            ret_cnt_reg   <= ret_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        base_next      = base_reg;
        issue_cnt_next = issue_cnt_reg;
        ret_cnt_next   = ret_cnt_reg;
        mem_en         = 1'b0;
        mem_wr         = 1'b0;
        mem_addr       = 16'h0000;
        mem_data_in    = 16'h0000;
        fill_data      = 16'h0000;
        fill_word      = 3'd0;
        d_wr_ack       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (d_wr) begin
                    state_next = WRITE;
                end else if (d_miss || i_miss) begin
                    owner_next     = grant_d;
                    base_next      = (grant_d ? d_addr : i_addr) & 16'hFFF0;
                    issue_cnt_next = '0;
                    ret_cnt_next   = '0;
                    state_next     = FILL;
                end
            end
            WRITE: begin
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_wr_addr;
                mem_data_in = d_wr_data;
                d_wr_ack    = 1'b1;
                state_next  = IDLE;
            end
            FILL: begin
                // Offset is OR-ed in, so no carry can reach the block base
                mem_en         = 1'b1;
                mem_addr       = base_reg | 16'({issue_cnt_reg, 1'b0});
                issue_cnt_next = issue_cnt_reg + 1'b1;
                if (issue_cnt_reg == CW'(BLOCK_WORDS - 1)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Waiting for the remaining in-flight reads
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Return counting runs alongside issuing; FILL and DRAIN overlap here
        if (ret_fire) begin
            fill_data    = mem_data_out;
            fill_word    = 3'(ret_cnt_reg);
            ret_cnt_next = ret_cnt_reg + 1'b1;
            if (last_ret) begin
                state_next = IDLE;
            end
        end
    end

endmodule
